// File: rtl/load_store_unit.sv
// Load/store unit for an RV32I core: decodes one LOAD/STORE, performs the
// memory handshake, aligns load data for write-back and flags faults
// (illegal funct3, misaligned address, memory timeout).
//
// Handshake rules:
//   mem_req/mem_gnt : mem_req is high for the whole REQ state; mem_addr,
//                     mem_we, mem_wdata and mem_be stay stable until the
//                     cycle in which mem_gnt is sampled high (the transfer
//                     cycle). mem_req is low in the following cycle.
//   mem_rvalid      : sampled only in WAIT; mem_rdata is captured in the
//                     same cycle. A mem_rvalid in any other state is ignored.
//   done            : one-cycle pulse in DONE; fault is meaningful only
//                     while done is high.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [31:0] inst,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] busW,
   output logic        reg_wr,
   output logic [4:0]  wb_rd,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [1:0]  state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // Counter must be able to hold TIMEOUT itself: a grant in the last
   // allowed REQ cycle still advances it into WAIT.
   localparam int unsigned CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);

   logic [2:0]    f3;
   logic          is_load;
   logic          is_store;
   logic          legal;
   logic          misalign;
   logic [11:0]   imm;
   logic [31:0]   ea;
   logic [3:0]    be_n;
   logic [31:0]   wdata_n;
   logic          accept;

   logic          load_q;
   logic          store_q;
   logic [2:0]    f3_q;
   logic [1:0]    addr_lo;
   logic [4:0]    rd_q;
   logic          fault_q;
   logic [CW-1:0] cnt;
   logic          timeout_hit;
   logic [31:0]   shifted;
   logic [31:0]   load_data;

   // Register-index field of rs1 is not needed here; the core supplies rs1 data.
   logic          unused_ok;
   assign unused_ok = ^inst[19:15];

   assign f3     = inst[14:12];
   assign accept = start && (state == S_IDLE) && (is_load || is_store);

   // Decode the incoming instruction: address, legality and store lane layout.
   always_comb begin
      is_load  = (inst[6:0] == OP_LOAD);
      is_store = (inst[6:0] == OP_STORE);
      imm      = is_store ? {inst[31:25], inst[11:7]} : inst[31:20];
      ea       = rs1 + {{20{imm[11]}}, imm};
      legal    = 1'b0;
      if (is_load) begin
         legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end else if (is_store) begin
         legal = (f3 inside {3'b000, 3'b001, 3'b010});
      end
      misalign = ((f3[1:0] == 2'b01) && ea[0]) ||
                 ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
      be_n     = 4'b1111;
      wdata_n  = 32'h0;
      if (is_store) begin
         case (f3[1:0])
            2'b00: begin
               be_n    = 4'b0001 << ea[1:0];
               wdata_n = {4{rs2[7:0]}};
            end
            2'b01: begin
               be_n    = ea[1] ? 4'b1100 : 4'b0011;
               wdata_n = {2{rs2[15:0]}};
            end
            default: begin
               be_n    = 4'b1111;
               wdata_n = rs2;
            end
         endcase
      end
   end

   // Select and extend the addressed byte/halfword of the returned word.
   always_comb begin
      shifted = mem_rdata >> {addr_lo, 3'b000};
      case (f3_q)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'h0, shifted[7:0]};
         3'b101:  load_data = {16'h0, shifted[15:0]};
         default: load_data = mem_rdata;
      endcase
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt >= CNT_LAST);

   // Control state, latched request payload, timeout counter and load result.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_be    <= 4'h0;
         load_q    <= 1'b0;
         store_q   <= 1'b0;
         f3_q      <= 3'b000;
         addr_lo   <= 2'b00;
         rd_q      <= 5'd0;
         fault_q   <= 1'b0;
         cnt       <= '0;
         busW      <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mem_addr  <= {ea[31:2], 2'b00};
                  mem_wdata <= wdata_n;
                  mem_be    <= be_n;
                  load_q    <= is_load;
                  store_q   <= is_store;
                  f3_q      <= f3;
                  addr_lo   <= ea[1:0];
                  rd_q      <= inst[11:7];
                  cnt       <= '0;
                  if (!legal || misalign) begin
                     fault_q <= 1'b1;
                     state   <= S_DONE;
                  end else begin
                     fault_q <= 1'b0;
                     state   <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_gnt) begin
                  cnt   <= cnt + 1'b1;
                  state <= load_q ? S_WAIT : S_DONE;
               end else if (timeout_hit) begin
                  fault_q <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  busW  <= load_data;
                  state <= S_DONE;
               end else if (timeout_hit) begin
                  fault_q <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_req = (state == S_REQ);
   assign mem_we  = mem_req && store_q;
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign fault   = done && fault_q;
   assign reg_wr  = done && load_q && !fault_q && (rd_q != 5'd0);
   assign wb_rd   = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: randomized and directed LOAD/STORE traffic
// against a behavioural model, with a scoreboard monitor for memory
// requests and completions, plus a short-TIMEOUT instance for timeouts.
module tb_load_store_unit;

   logic clk;
   logic resetn;

   // Main instance (default TIMEOUT)
   logic        start, mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] inst, rs1, rs2, mem_addr, mem_wdata, mem_rdata, busW;
   logic [3:0]  mem_be;
   logic        reg_wr, busy, done, fault;
   logic [4:0]  wb_rd;
   logic [1:0]  dbg_state;

   // Short-timeout instance
   logic        t_start, t_mem_req, t_mem_we, t_mem_gnt, t_mem_rvalid;
   logic [31:0] t_inst, t_rs1, t_rs2, t_mem_addr, t_mem_wdata, t_mem_rdata, t_busW;
   logic [3:0]  t_mem_be;
   logic        t_reg_wr, t_busy, t_done, t_fault;
   logic [4:0]  t_wb_rd;
   logic [1:0]  t_dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   // Expected memory requests {we, be, addr, wdata} and completions
   // {fault, reg_wr, wb_rd, busW}.
   logic [68:0] req_q[$];
   logic [38:0] resp_q[$];
   logic [31:0] model_busw;

   load_store_unit dut (
      .clk(clk), .resetn(resetn), .start(start), .inst(inst), .rs1(rs1), .rs2(rs2),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busW(busW), .reg_wr(reg_wr), .wb_rd(wb_rd), .busy(busy), .done(done),
      .fault(fault), .state(dbg_state)
   );

   load_store_unit #(.TIMEOUT(4)) dut_t (
      .clk(clk), .resetn(resetn), .start(t_start), .inst(t_inst), .rs1(t_rs1), .rs2(t_rs2),
      .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
      .mem_be(t_mem_be), .mem_gnt(t_mem_gnt), .mem_rvalid(t_mem_rvalid), .mem_rdata(t_mem_rdata),
      .busW(t_busW), .reg_wr(t_reg_wr), .wb_rd(t_wb_rd), .busy(t_busy), .done(t_done),
      .fault(t_fault), .state(t_dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog
   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_load(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [11:0] imm);
      return {imm, 5'd1, f3, rd, 7'b0000011};
   endfunction

   function automatic logic [31:0] mk_store(input logic [2:0] f3, input logic [11:0] imm);
      return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
   endfunction

   // Reference load extraction with plain arithmetic.
   function automatic logic [31:0] load_value(input logic [2:0] f3, input int off,
                                              input logic [31:0] rdata);
      logic [31:0] w, b, h;
      w = rdata >> (8 * off);
      b = w & 32'hFF;
      h = w & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'h10000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   task automatic check_reset_outs(input string tag);
      check({tag, "_ctl"}, 69'({mem_req, mem_we, mem_be, reg_wr, wb_rd, busy, done, fault}), 69'(0));
      check({tag, "_addr_wdata"}, 69'({mem_addr, mem_wdata}), 69'(0));
      check({tag, "_busW"}, 69'(busW), 69'(0));
   endtask

   // One instruction through the main instance, memory responding after
   // gdly cycles of grant hold-off and rdly extra cycles before rvalid.
   task automatic run_txn(input logic [31:0] ti, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdata, input int gdly, input int rdly,
                          input bit poke_done);
      bit          is_ld, is_st, lgl, flt, wr_e;
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [31:0] ea, wd;
      logic [3:0]  be;
      int          size, off, exp_lat, lat, g, r;
      is_ld = (ti[6:0] == 7'b0000011);
      is_st = (ti[6:0] == 7'b0100011);
      start = 1'b1; inst = ti; rs1 = a; rs2 = d;
      if (!is_ld && !is_st) begin
         tick();
         start = 1'b0;
         check("ignored_opcode_busy", 69'(busy), 69'(0));
         return;
      end
      f3   = ti[14:12];
      imm  = is_st ? {ti[31:25], ti[11:7]} : ti[31:20];
      ea   = a + 32'($signed(imm));
      size = 1 << f3[1:0];
      off  = int'(ea % 4);
      lgl  = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
      flt  = !lgl || ((ea % size) != 0);
      if (!flt) begin
         be = 4'hF;
         wd = d;
         if (is_st && size == 1) begin be = 4'(1 << off); wd = d[7:0] * 32'h01010101; end
         if (is_st && size == 2) begin be = (off >= 2) ? 4'hC : 4'h3; wd = d[15:0] * 32'h00010001; end
         req_q.push_back({is_st, be, ea & 32'hFFFF_FFFC, wd});
         if (is_ld) model_busw = load_value(f3, off, rdata);
      end
      wr_e = is_ld && !flt && (ti[11:7] != 5'd0);
      resp_q.push_back({flt, wr_e, ti[11:7], model_busw});
      exp_lat = flt ? 2 : (is_st ? 3 + gdly : 4 + gdly + rdly);
      lat = 1;
      g = gdly;
      r = -1;
      tick();
      lat++;
      start = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         inst = $urandom; rs1 = $urandom; rs2 = $urandom;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (mem_req) begin
            if (g == 0) begin
               mem_gnt = 1'b1;
               r = is_ld ? rdly : -1;
            end else begin
               g--;
            end
         end else if (r == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
            r = -1;
         end else if (r > 0) begin
            r--;
         end
         tick();
         lat++;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: no done within 64 cycles for inst %h, required done", ti);
      end else begin
         check("latency", 69'(lat), 69'(exp_lat));
      end
      // DONE cycle: a start here and a stray rvalid both have to be ignored.
      mem_rvalid = 1'($urandom_range(0, 1));
      if (poke_done) begin
         start = 1'b1; inst = mk_load(3'd2, 5'd5, 12'd0); rs1 = 32'h0;
      end
      tick();
      start = 1'b0; mem_rvalid = 1'b0;
   endtask

   // Short-TIMEOUT instance: grant (for a load) but never rvalid, or never
   // grant (for a store); either way 4 cycles in REQ+WAIT then faulting done.
   task automatic timeout_case(input logic [31:0] ti, input bit give_gnt);
      int lat;
      t_start = 1'b1; t_inst = ti; t_rs1 = 32'h100; t_rs2 = $urandom;
      lat = 1;
      tick();
      lat++;
      t_start = 1'b0;
      for (int c = 0; c < 20 && !t_done; c++) begin
         t_mem_gnt = give_gnt && t_mem_req;
         tick();
         lat++;
      end
      t_mem_gnt = 1'b0;
      if (!t_done) begin
         n_cmp++; n_err++;
         $display("FAIL timeout_done: no done within 20 cycles, required faulting done");
      end else begin
         check("timeout_latency", 69'(lat), 69'(6));
         check("timeout_fault_regwr_req", 69'({t_fault, t_reg_wr, t_mem_req}), 69'(3'b100));
      end
      tick();
      t_mem_rvalid = 1'b1; t_mem_rdata = 32'hFFFF_FFFF;
      tick();
      t_mem_rvalid = 1'b0;
      check("timeout_late_rvalid", 69'({t_busy, t_done, t_busW}), 69'(0));
   endtask

   task automatic reset_in_wait();
      req_q.push_back({1'b0, 4'hF, 32'h0000_0508, 32'h0});
      start = 1'b1; inst = mk_load(3'd2, 5'd4, 12'd8); rs1 = 32'h500;
      tick();
      start = 1'b0;
      mem_gnt = mem_req;
      tick();
      mem_gnt = 1'b0;
      check("wait_busy_before_reset", 69'({busy, mem_req}), 69'(2'b10));
      resetn = 1'b0;
      #1;
      check_reset_outs("async_reset");
      model_busw = 32'h0;
      tick();
      tick();
      resetn = 1'b1;
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_rvalid = 1'b0;
      check("late_rvalid_ignored", 69'({busy, done, busW}), 69'(0));
   endtask

   // Scoreboard monitor: compares DUT requests/completions with the queues.
   always @(negedge clk) begin
      logic [68:0] e_req, a_req;
      if (resetn) begin
         if (mem_req) begin
            if (req_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_mem_req: got addr %h, required no request", mem_addr);
            end else begin
               e_req = req_q[0];
               a_req = {mem_we, mem_be, mem_addr, mem_wdata};
               if (!e_req[68]) begin
                  e_req[31:0] = 32'h0;
                  a_req[31:0] = 32'h0;
               end
               check("mem_request", a_req, e_req);
               if (mem_gnt) void'(req_q.pop_front());
            end
         end
         if (done) begin
            if (resp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_done: got done, required none");
            end else begin
               check("completion", 69'({fault, reg_wr, wb_rd, busW}), 69'(resp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [31:0] ti, a;
      int          k;
      start = 0; inst = 0; rs1 = 0; rs2 = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      t_start = 0; t_inst = 0; t_rs1 = 0; t_rs2 = 0; t_mem_gnt = 0; t_mem_rvalid = 0; t_mem_rdata = 0;
      model_busw = 32'h0;
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #2 check_reset_outs("reset");
      repeat (3) tick();
      resetn = 1'b1;
      tick();

      // Directed cases
      run_txn(mk_load(3'd2, 5'd5, 12'd4), 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0);
      check("lw_busW", 69'({busW}), 69'(32'hDEADBEEF));
      run_txn(mk_load(3'd0, 5'd6, 12'd3), 32'h2000, 32'h0, 32'h80FFFFFF, 1, 0, 0);
      check("lb_busW", 69'(busW), 69'(32'hFFFFFF80));
      run_txn(mk_load(3'd4, 5'd7, 12'd3), 32'h2000, 32'h0, 32'h80FFFFFF, 0, 2, 0);
      check("lbu_busW", 69'(busW), 69'(32'h00000080));
      run_txn(mk_load(3'd5, 5'd8, 12'd2), 32'h2000, 32'h0, 32'h8001ABCD, 0, 0, 1);
      check("lhu_busW", 69'(busW), 69'(32'h00008001));
      run_txn(mk_store(3'd1, 12'd2), 32'h3000, 32'h1234ABCD, 32'h0, 3, 0, 0);
      check("sh_keeps_busW", 69'(busW), 69'(32'h00008001));
      run_txn(mk_load(3'd2, 5'd9, 12'd2), 32'h1000, 32'h0, 32'h0, 0, 0, 0);
      run_txn(mk_load(3'd3, 5'd9, 12'd0), 32'h1000, 32'h0, 32'h0, 0, 0, 0);
      run_txn(mk_store(3'd4, 12'd0), 32'h1000, 32'h0, 32'h0, 0, 0, 0);
      run_txn(32'h0020_80B3, 32'h1000, 32'h0, 32'h0, 0, 0, 0);
      run_txn(mk_store(3'd0, 12'hFFF), 32'h0000_4000, 32'h0000_00A5, 32'h0, 0, 0, 1);
      run_txn(mk_load(3'd2, 5'd0, 12'd0), 32'h40, 32'h0, 32'h5555_AAAA, 0, 1, 0);

      reset_in_wait();
      run_txn(mk_load(3'd2, 5'd3, 12'd0), 32'h600, 32'h0, 32'h0BADF00D, 0, 0, 0);
      check("lw_after_reset_busW", 69'(busW), 69'(32'h0BADF00D));

      timeout_case(mk_load(3'd2, 5'd3, 12'd0), 1'b1);
      timeout_case(mk_store(3'd2, 12'd0), 1'b0);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 9);
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         if (k == 0) begin
            ti = $urandom;
            ti[6:0] = 7'b0110011;
         end else if (k <= 5) begin
            ti = mk_load(3'($urandom_range(0, 7)), 5'($urandom), 12'($urandom));
         end else begin
            ti = mk_store(3'($urandom_range(0, 3)), 12'($urandom));
         end
         run_txn(ti, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end

      repeat (3) tick();
      check("req_queue_drained", 69'(req_q.size()), 69'(0));
      check("resp_queue_drained", 69'(resp_q.size()), 69'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
